// File: rtl/decoder_scan_ctrl_if.sv
// Bundle between the scan controller and its requester: control inputs plus
// the registered 3-8 decoder pin drive and status.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [7:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               E1_n;
    logic               E2_n;
    logic               E3;
    logic               A2;
    logic               A1;
    logic               A0;
    logic               busy;
    logic               frame_done;

    modport master (
        output start, stop, chan_mask, dwell,
        input  E1_n, E2_n, E3, A2, A1, A0, busy, frame_done
    );

    modport slave (
        input  start, stop, chan_mask, dwell,
        output E1_n, E2_n, E3, A2, A1, A0, busy, frame_done
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Round-robin channel scanner for a 3-8 active-low decoder, with a one-cycle
// blanking gap around every address change so no two outputs overlap.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    decoder_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    // {E1_n, E2_n, E3}
    localparam logic [2:0] EN_ON  = 3'b001;
    localparam logic [2:0] EN_OFF = 3'b110;

    state_t             state;
    logic               stop_pend;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         mask_q;
    logic [2:0]         addr;
    logic [2:0]         en_q;
    logic               busy_q;
    logic               frame_done_q;
    logic [3:0]         nxt;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // {found, index} of the next set bit strictly above cur; found=0 means wrap.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--)
            if (i > int'(cur) && m[i]) r = {1'b1, 3'(i)};
        return r;
    endfunction

    assign nxt = next_above(mask_q, addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stop_pend    <= 1'b0;
            cnt          <= '0;
            dwell_q      <= '0;
            mask_q       <= '0;
            addr         <= 3'd0;
            en_q         <= EN_OFF;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && bus.chan_mask != 8'd0) begin
                        mask_q  <= bus.chan_mask;
                        dwell_q <= bus.dwell;
                        addr    <= lowest_set(bus.chan_mask);
                        state   <= BLANK;
                        busy_q  <= 1'b1;
                    end
                end
                BLANK: begin
                    if (bus.stop) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        state <= DRIVE;
                        cnt   <= '0;
                        en_q  <= EN_ON;
                    end
                end
                DRIVE: begin
                    if (cnt != dwell_q) begin
                        cnt <= cnt + 1'b1;
                        if (bus.stop) stop_pend <= 1'b1;
                    end else begin
                        en_q <= EN_OFF;
                        if (stop_pend || bus.stop) begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            stop_pend <= 1'b0;
                        end else if (nxt[3]) begin
                            addr  <= nxt[2:0];
                            state <= BLANK;
                        end else begin
                            // Frame end: pick up new mask/dwell only here.
                            frame_done_q <= 1'b1;
                            mask_q       <= bus.chan_mask;
                            dwell_q      <= bus.dwell;
                            if (bus.chan_mask == 8'd0) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                addr  <= lowest_set(bus.chan_mask);
                                state <= BLANK;
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    en_q   <= EN_OFF;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.E1_n       = en_q[2];
    assign bus.E2_n       = en_q[1];
    assign bus.E3         = en_q[0];
    assign bus.A2         = addr[2];
    assign bus.A1         = addr[1];
    assign bus.A0         = addr[0];
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule
